sub_bytes_seq: RTL and testbench



---
 rtl/sub_bytes_seq.sv | 152 +++++++++++++++
 tb/tb_sub_bytes_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: BYTES_PER_CYCLE sbox lanes walk the 16 state bytes.
// Optional SUB_BYTES_INV_EN adds inv_mode for InvSubBytes in the decryption path.
module sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
`ifdef SUB_BYTES_INV_EN
  ,
  input  logic         inv_mode
`endif
);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
    $error("sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [3:0] IDX_STEP = 4'(BYTES_PER_CYCLE);
  localparam logic [3:0] IDX_LAST = 4'(16 - BYTES_PER_CYCLE);

  state_e       state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [127:0] work_q, work_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ t;
      t = xtime(t);
    end
    return r;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
           {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

`ifdef SUB_BYTES_INV_EN
  logic mode_q, mode_d;

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] x, input logic inv);
    return inv ? sbox_inv(x) : sbox_fwd(x);
  endfunction
`else
  function automatic logic [7:0] sub_byte(input logic [7:0] x, input logic inv);
    logic unused_inv;
    unused_inv = inv;
    return sbox_fwd(x);
  endfunction
`endif

  always_comb begin
    logic [3:0] pos;
    logic       inv_sel;
    state_d = state_q;
    idx_d   = idx_q;
    work_d  = work_q;
    pos     = 4'd0;
`ifdef SUB_BYTES_INV_EN
    mode_d  = mode_q;
    inv_sel = mode_q;
`else
    inv_sel = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          idx_d   = 4'd0;
          state_d = RUN;
`ifdef SUB_BYTES_INV_EN
          mode_d  = inv_mode;
`endif
        end
      end
      RUN: begin
        // Byte 0 sits in the top bits, so lane position pos maps to bit 8*(15-pos).
        for (int b = 0; b < BYTES_PER_CYCLE; b++) begin
          pos = idx_q + 4'(b);
          work_d[8*(15-int'(pos)) +: 8] = sub_byte(work_q[8*(15-int'(pos)) +: 8], inv_sel);
        end
        idx_d = idx_q + IDX_STEP;
        if (idx_q == IDX_LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      work_q  <= '0;
`ifdef SUB_BYTES_INV_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
`ifdef SUB_BYTES_INV_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_state = work_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Randomized bench for sub_bytes_seq: three instances (1, 4, 16 bytes/cycle)
// checked against a table-driven AES sbox model built by generator iteration.
module tb_sub_bytes_seq;

  logic         clk;
  logic         rst_n     [3];
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];
  logic         busy      [3];
`ifdef SUB_BYTES_INV_EN
  logic         inv_mode  [3];
  bit           toggle_inv;
`endif

  int n_checks;
  int n_fail;

  logic [7:0] sbox_t [256];
  logic [7:0] isbox_t [256];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sub_bytes_seq #(.BYTES_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 4 : 16))) u_dut (
      .clk      (clk),
      .rst_n    (rst_n[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_state (in_state[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_state(out_state[g]),
      .busy     (busy[g])
`ifdef SUB_BYTES_INV_EN
      ,
      .inv_mode (inv_mode[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // Walk GF(2^8)* with generator 3 and its inverse 1/3 together.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ 8'(p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ 8'(q << 1);
      q = q ^ 8'(q << 2);
      q = q ^ 8'(q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
  endtask

  function automatic logic [127:0] model(input logic [127:0] s, input bit inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = inv ? isbox_t[s[127-8*i -: 8]] : sbox_t[s[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_block(input int k, input logic [127:0] data,
                           output logic [127:0] got, output int lat);
    int guard;
    guard = 0;
    while (!in_ready[k] && guard < 100) begin
      step();
      guard++;
    end
    in_valid[k] = 1'b1;
    in_state[k] = data;
    step();
    in_valid[k] = 1'b0;
    in_state[k] = rnd128();
    lat = 0;
    while (!out_valid[k] && lat < 64) begin
`ifdef SUB_BYTES_INV_EN
      if (toggle_inv) inv_mode[k] = ~inv_mode[k];
`endif
      step();
      lat++;
    end
    if (!out_valid[k]) chk("out_valid_timeout", 128'(out_valid[k]), 128'd1);
    got = out_state[k];
  endtask

  initial begin
    logic [127:0] got, exp;
    logic [127:0] b2b_data [10];
    logic [127:0] exp_q [$];
    int lat, acc, outs, cyc, last_acc;
    bit accepted;

    n_checks = 0;
    n_fail   = 0;
    build_tables();
    for (int k = 0; k < 3; k++) begin
      rst_n[k]     = 1'b0;
      in_valid[k]  = 1'b0;
      in_state[k]  = '0;
      out_ready[k] = 1'b1;
`ifdef SUB_BYTES_INV_EN
      inv_mode[k]  = 1'b0;
`endif
    end
`ifdef SUB_BYTES_INV_EN
    toggle_inv = 1'b0;
`endif

    step();
    step();
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", 128'(busy[k]), 128'd0);
      chk("rst_out_valid", 128'(out_valid[k]), 128'd0);
      chk("rst_in_ready", 128'(in_ready[k]), 128'd1);
      chk("rst_out_state", out_state[k], 128'd0);
      rst_n[k] = 1'b1;
    end

    // All-zero state, one byte per cycle.
    run_block(0, 128'd0, got, lat);
    chk("zero_data", got, {16{8'h63}});
    chk("zero_model", got, model(128'd0, 1'b0));
    chk("zero_latency", 128'(lat), 128'd16);
    step();
    chk("zero_valid_drop", 128'(out_valid[0]), 128'd0);
    chk("zero_ready_back", 128'(in_ready[0]), 128'd1);

    // FIPS-197 round-1 vector, four bytes per cycle.
    run_block(1, 128'h193de3bea0f4e22b9ac68d2ae9f84808, got, lat);
    chk("fips_data", got, 128'hd42711aee0bf98f1b8b45de51e415230);
    chk("fips_latency", 128'(lat), 128'd4);
    step();

    // Random states on every lane width.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 6; n++) begin
        logic [127:0] d;
        d = rnd128();
        run_block(k, d, got, lat);
        chk("rand_data", got, model(d, 1'b0));
        chk("rand_latency", 128'(lat), 128'(k == 0 ? 16 : (k == 1 ? 4 : 1)));
        step();
      end
    end

    // Backpressure with an ignored in_valid pulse.
    out_ready[1] = 1'b0;
    run_block(1, {16{8'hff}}, got, lat);
    chk("bp_data", got, {16{8'h16}});
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_state", out_state[1], {16{8'h16}});
      chk("bp_hold_valid", 128'(out_valid[1]), 128'd1);
      chk("bp_hold_in_ready", 128'(in_ready[1]), 128'd0);
      in_valid[1] = (c == 2);
      in_state[1] = rnd128();
      step();
      in_valid[1] = 1'b0;
    end
    chk("bp_still_state", out_state[1], {16{8'h16}});
    out_ready[1] = 1'b1;
    step();
    chk("bp_done_valid", 128'(out_valid[1]), 128'd0);
    chk("bp_done_busy", 128'(busy[1]), 128'd0);
    chk("bp_done_in_ready", 128'(in_ready[1]), 128'd1);

    // Reset in the middle of RUN at idx=8.
    in_valid[0] = 1'b1;
    in_state[0] = rnd128();
    step();
    in_valid[0] = 1'b0;
    for (int c = 0; c < 8; c++) step();
    chk("mid_busy_before", 128'(busy[0]), 128'd1);
    rst_n[0] = 1'b0;
    step();
    rst_n[0] = 1'b1;
    chk("mid_rst_busy", 128'(busy[0]), 128'd0);
    chk("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("mid_rst_in_ready", 128'(in_ready[0]), 128'd1);
    chk("mid_rst_out_state", out_state[0], 128'd0);
    run_block(0, 128'h0102030405060708090a0b0c0d0e0f10, got, lat);
    chk("mid_fresh_data", got, 128'h7c777bf26b6fc53001672bfed7ab76ca);
    chk("mid_fresh_latency", 128'(lat), 128'd16);
    step();

    // Back-to-back at 16 bytes per cycle with in_valid held high.
    for (int n = 0; n < 10; n++) b2b_data[n] = rnd128();
    out_ready[2] = 1'b1;
    in_valid[2]  = 1'b1;
    in_state[2]  = b2b_data[0];
    acc = 0;
    outs = 0;
    cyc = 0;
    last_acc = 0;
    while (outs < 10 && cyc < 200) begin
      accepted = in_valid[2] && in_ready[2];
      if (accepted) begin
        exp_q.push_back(model(in_state[2], 1'b0));
        if (acc > 0) chk("b2b_gap", 128'(cyc - last_acc), 128'd3);
        last_acc = cyc;
        acc++;
      end
      step();
      cyc++;
      if (accepted) begin
        if (acc < 10) in_state[2] = b2b_data[acc];
        else in_valid[2] = 1'b0;
      end
      if (out_valid[2]) begin
        if (exp_q.size() == 0) chk("b2b_extra", 128'd1, 128'd0);
        else begin
          exp = exp_q.pop_front();
          chk("b2b_data", out_state[2], exp);
        end
        outs++;
      end
    end
    in_valid[2] = 1'b0;
    chk("b2b_outputs", 128'(outs), 128'd10);
    chk("b2b_accepts", 128'(acc), 128'd10);
    chk("b2b_leftover", 128'(exp_q.size()), 128'd0);
    step();

`ifdef SUB_BYTES_INV_EN
    inv_mode[1] = 1'b1;
    run_block(1, {16{8'h63}}, got, lat);
    chk("inv_63", got, 128'd0);
    step();
    inv_mode[1] = 1'b1;
    run_block(1, {16{8'h16}}, got, lat);
    chk("inv_16", got, {16{8'hff}});
    step();
    toggle_inv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int m = 0; m < 2; m++) begin
        logic [127:0] d;
        d = rnd128();
        inv_mode[k] = m[0];
        run_block(k, d, got, lat);
        chk("inv_toggle_data", got, model(d, m[0]));
        step();
      end
    end
    toggle_inv = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
